// File: rtl/sd_cmd_serdes.sv
`default_nettype none
// ============================================================================
//  Module      : sd_cmd_serdes
//  Description : SD CMD-line serializer/deserializer. Builds and shifts out
//                48-bit command frames with CRC7, and captures 48/136-bit
//                responses with CRC7 and end-bit checking.
//  Revision    : 1.0 - initial release
// ============================================================================
module sd_cmd_serdes #(
    parameter int CMD_BITS        = 48,
    parameter int SHORT_RESP_BITS = 48,
    parameter int LONG_RESP_BITS  = 136
) (
    input  logic                      sd_clock,
    input  logic                      reset,
    input  logic                      reset_wrapper,
    input  logic                      enable_pts,
    input  logic                      enable_stp,
    input  logic                      load_send,
    input  logic [5:0]                cmd_index,
    input  logic [31:0]               cmd_arg,
    input  logic                      long_response,
    input  logic                      cmd_in,
    output logic                      cmd_out,
    output logic                      cmd_oe,
    output logic                      transmission_complete,
    output logic                      reception_complete,
    output logic [LONG_RESP_BITS-1:0] pad_response,
    output logic                      crc_error,
    output logic                      end_bit_error
);

    localparam int TX_CNT_W  = $clog2(CMD_BITS + 1);
    localparam int TX_DATA_W = CMD_BITS - 8;
    localparam int RX_CNT_W  = $clog2(LONG_RESP_BITS);
    localparam int PAD_W     = LONG_RESP_BITS - SHORT_RESP_BITS;

    // Bit-position milestones of the outgoing frame (counted in bits already sent)
    localparam logic [TX_CNT_W-1:0] c_tx_crc_first = TX_CNT_W'(CMD_BITS - 8);
    localparam logic [TX_CNT_W-1:0] c_tx_end_bit   = TX_CNT_W'(CMD_BITS - 1);
    localparam logic [TX_CNT_W-1:0] c_tx_done      = TX_CNT_W'(CMD_BITS);
    localparam logic [TX_CNT_W-1:0] c_tx_one       = TX_CNT_W'(1);

    // Frame-bit indices of the incoming response
    localparam logic [RX_CNT_W-1:0] c_rx_short_first = RX_CNT_W'(SHORT_RESP_BITS - 2);
    localparam logic [RX_CNT_W-1:0] c_rx_long_first  = RX_CNT_W'(LONG_RESP_BITS - 2);
    localparam logic [RX_CNT_W-1:0] c_rx_crc_lo      = RX_CNT_W'(8);
    localparam logic [RX_CNT_W-1:0] c_rx_crc_hi      = RX_CNT_W'(LONG_RESP_BITS - 9);
    localparam logic [RX_CNT_W-1:0] c_rx_one         = RX_CNT_W'(1);

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_SHIFT = 2'd1,
        TX_DONE  = 2'd2
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_WAIT  = 2'd1,
        RX_SHIFT = 2'd2,
        RX_DONE  = 2'd3
    } rx_state_t;

    // One serial step of CRC7, generator x^7 + x^3 + 1
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
        logic       fb;
        logic [6:0] nxt;
        fb     = bit_in ^ crc[6];
        nxt    = {crc[5:0], fb};
        nxt[3] = crc[2] ^ fb;
        return nxt;
    endfunction

    tx_state_t               r_tx_state;
    tx_state_t               w_tx_state_next;
    logic [TX_CNT_W-1:0]     r_tx_cnt;
    logic [TX_DATA_W-1:0]    r_tx_data;
    logic [6:0]              r_tx_crc;
    logic                    r_cmd_out;

    rx_state_t               r_rx_state;
    rx_state_t               w_rx_state_next;
    logic [RX_CNT_W-1:0]     r_rx_cnt;
    logic [LONG_RESP_BITS-2:0] r_rx_shift;
    logic [6:0]              r_rx_crc;
    logic                    r_rx_long;
    logic [LONG_RESP_BITS-1:0] w_rx_full;

    // Output enable and completion levels come straight from the state
    // registers, so an asynchronous reset releases the pad immediately.
    assign cmd_out               = r_cmd_out;
    assign cmd_oe                = (r_tx_state == TX_SHIFT);
    assign transmission_complete = (r_tx_state == TX_DONE);
    assign reception_complete    = (r_rx_state == RX_DONE);
    assign w_rx_full             = {r_rx_shift, cmd_in};

    // TX next-state: start on load, abort when the path is disabled
    always_comb begin
        w_tx_state_next = r_tx_state;
        case (r_tx_state)
            TX_IDLE:  if (enable_pts && load_send) w_tx_state_next = TX_SHIFT;
            TX_SHIFT: begin
                if (!enable_pts)                w_tx_state_next = TX_IDLE;
                else if (r_tx_cnt == c_tx_done) w_tx_state_next = TX_DONE;
            end
            TX_DONE:  if (!enable_pts) w_tx_state_next = TX_IDLE;
            default:  w_tx_state_next = TX_IDLE;
        endcase
    end

    // TX state register
    always_ff @(posedge sd_clock or negedge reset) begin
        if (!reset)             r_tx_state <= TX_IDLE;
        else if (reset_wrapper) r_tx_state <= TX_IDLE;
        else                    r_tx_state <= w_tx_state_next;
    end

    // TX datapath: header/index/argument, then CRC7, then end bit
    always_ff @(posedge sd_clock or negedge reset) begin
        if (!reset) begin
            r_tx_cnt  <= '0;
            r_tx_data <= '0;
            r_tx_crc  <= '0;
            r_cmd_out <= 1'b1;
        end else if (reset_wrapper) begin
            r_tx_cnt  <= '0;
            r_tx_data <= '0;
            r_tx_crc  <= '0;
            r_cmd_out <= 1'b1;
        end else begin
            case (r_tx_state)
                TX_IDLE: begin
                    if (w_tx_state_next == TX_SHIFT) begin
                        // Start bit goes out now; the shifter holds the rest of
                        // the header. A leading 0 leaves a zero CRC unchanged.
                        r_cmd_out <= 1'b0;
                        r_tx_data <= {1'b1, cmd_index, cmd_arg, 1'b0};
                        r_tx_crc  <= '0;
                        r_tx_cnt  <= c_tx_one;
                    end
                end
                TX_SHIFT: begin
                    if (w_tx_state_next != TX_SHIFT) begin
                        r_cmd_out <= 1'b1;
                        r_tx_cnt  <= '0;
                        r_tx_crc  <= '0;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + c_tx_one;
                        if (r_tx_cnt < c_tx_crc_first) begin
                            r_cmd_out <= r_tx_data[TX_DATA_W-1];
                            r_tx_crc  <= crc7_step(r_tx_crc, r_tx_data[TX_DATA_W-1]);
                            r_tx_data <= {r_tx_data[TX_DATA_W-2:0], 1'b0};
                        end else if (r_tx_cnt < c_tx_end_bit) begin
                            r_cmd_out <= r_tx_crc[6];
                            r_tx_crc  <= {r_tx_crc[5:0], 1'b0};
                        end else begin
                            r_cmd_out <= 1'b1;
                        end
                    end
                end
                default: r_cmd_out <= 1'b1;
            endcase
        end
    end

    // RX next-state: never leave idle while TX owns or may own the line
    always_comb begin
        w_rx_state_next = r_rx_state;
        case (r_rx_state)
            RX_IDLE:  if (enable_stp && !enable_pts && !cmd_oe) w_rx_state_next = RX_WAIT;
            RX_WAIT: begin
                if (!enable_stp)  w_rx_state_next = RX_IDLE;
                else if (!cmd_in) w_rx_state_next = RX_SHIFT;
            end
            RX_SHIFT: begin
                if (!enable_stp)          w_rx_state_next = RX_IDLE;
                else if (r_rx_cnt == '0)  w_rx_state_next = RX_DONE;
            end
            RX_DONE:  if (!enable_stp) w_rx_state_next = RX_IDLE;
            default:  w_rx_state_next = RX_IDLE;
        endcase
    end

    // RX state register
    always_ff @(posedge sd_clock or negedge reset) begin
        if (!reset)             r_rx_state <= RX_IDLE;
        else if (reset_wrapper) r_rx_state <= RX_IDLE;
        else                    r_rx_state <= w_rx_state_next;
    end

    // RX datapath: shift in response, accumulate CRC, publish on last bit
    always_ff @(posedge sd_clock or negedge reset) begin
        if (!reset) begin
            r_rx_cnt      <= '0;
            r_rx_shift    <= '0;
            r_rx_crc      <= '0;
            r_rx_long     <= 1'b0;
            pad_response  <= '0;
            crc_error     <= 1'b0;
            end_bit_error <= 1'b0;
        end else if (reset_wrapper) begin
            r_rx_cnt      <= '0;
            r_rx_shift    <= '0;
            r_rx_crc      <= '0;
            r_rx_long     <= 1'b0;
            pad_response  <= '0;
            crc_error     <= 1'b0;
            end_bit_error <= 1'b0;
        end else begin
            case (r_rx_state)
                RX_IDLE: begin
                    if (w_rx_state_next == RX_WAIT) r_rx_long <= long_response;
                end
                RX_WAIT: begin
                    if (w_rx_state_next == RX_SHIFT) begin
                        r_rx_shift <= w_rx_full[LONG_RESP_BITS-2:0];
                        r_rx_cnt   <= r_rx_long ? c_rx_long_first : c_rx_short_first;
                        r_rx_crc   <= '0;
                    end
                end
                RX_SHIFT: begin
                    if (w_rx_state_next == RX_DONE) begin
                        // Received CRC sits in frame bits 7..1, i.e. the low
                        // seven bits of the shifter before bit 0 arrives.
                        r_rx_shift    <= w_rx_full[LONG_RESP_BITS-2:0];
                        r_rx_cnt      <= '0;
                        pad_response  <= r_rx_long ? w_rx_full
                                                   : {{PAD_W{1'b0}}, w_rx_full[SHORT_RESP_BITS-1:0]};
                        crc_error     <= (r_rx_crc != r_rx_shift[6:0]);
                        end_bit_error <= ~cmd_in;
                    end else if (w_rx_state_next == RX_SHIFT) begin
                        r_rx_shift <= w_rx_full[LONG_RESP_BITS-2:0];
                        r_rx_cnt   <= r_rx_cnt - c_rx_one;
                        // Long responses skip their 8-bit header; short ones
                        // start at the start bit, which is 0 and leaves CRC unchanged.
                        if (r_rx_cnt >= c_rx_crc_lo && r_rx_cnt <= c_rx_crc_hi)
                            r_rx_crc <= crc7_step(r_rx_crc, cmd_in);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sd_cmd_serdes.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sd_cmd_serdes
//  Description : Self-checking bench for sd_cmd_serdes with a scoreboard and
//                a polynomial-division CRC7 reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sd_cmd_serdes;

    logic         sd_clock      = 1'b0;
    logic         reset         = 1'b0;
    logic         reset_wrapper = 1'b0;
    logic         enable_pts    = 1'b0;
    logic         enable_stp    = 1'b0;
    logic         load_send     = 1'b0;
    logic [5:0]   cmd_index     = '0;
    logic [31:0]  cmd_arg       = '0;
    logic         long_response = 1'b0;
    logic         cmd_in        = 1'b1;
    logic         cmd_out;
    logic         cmd_oe;
    logic         transmission_complete;
    logic         reception_complete;
    logic [135:0] pad_response;
    logic         crc_error;
    logic         end_bit_error;

    int total = 0;
    int bad   = 0;

    logic [47:0]  exp_tx_q[$];
    logic [135:0] exp_rx_q[$];
    logic [1:0]   exp_flag_q[$];

    always #5 sd_clock = ~sd_clock;

    sd_cmd_serdes dut (
        .sd_clock              (sd_clock),
        .reset                 (reset),
        .reset_wrapper         (reset_wrapper),
        .enable_pts            (enable_pts),
        .enable_stp            (enable_stp),
        .load_send             (load_send),
        .cmd_index             (cmd_index),
        .cmd_arg               (cmd_arg),
        .long_response         (long_response),
        .cmd_in                (cmd_in),
        .cmd_out               (cmd_out),
        .cmd_oe                (cmd_oe),
        .transmission_complete (transmission_complete),
        .reception_complete    (reception_complete),
        .pad_response          (pad_response),
        .crc_error             (crc_error),
        .end_bit_error         (end_bit_error)
    );

    task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // CRC7 as the remainder of msg * x^7 divided by x^7 + x^3 + 1 (0x89)
    function automatic logic [6:0] crc7_ref(input logic [127:0] msg, input int n);
        logic [6:0] r;
        logic [7:0] t;
        logic       b;
        r = '0;
        for (int i = n + 6; i >= 0; i--) begin
            b = (i >= 7) ? msg[i-7] : 1'b0;
            t = {r, b};
            if (t[7]) t = t ^ 8'h89;
            r = t[6:0];
        end
        return r;
    endfunction

    function automatic logic [47:0] cmd_frame(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] m;
        m = {2'b01, idx, arg};
        return {m, crc7_ref({88'd0, m}, 40), 1'b1};
    endfunction

    // Scoreboard monitor: collects serial TX bits and pops expectations on completion
    logic [47:0] mon_bits = '0;
    int          mon_n    = 0;
    logic        prev_tc  = 1'b0;
    logic        prev_rc  = 1'b0;
    always @(negedge sd_clock) begin
        if (cmd_oe) begin
            mon_bits = {mon_bits[46:0], cmd_out};
            mon_n++;
        end else if (transmission_complete && !prev_tc) begin
            if (exp_tx_q.size() == 0) begin
                total++; bad++;
                $display("FAIL tx_unexpected: got frame %h expected none", mon_bits);
            end else begin
                check("tx_frame", 136'(mon_bits), 136'(exp_tx_q.pop_front()));
                check("tx_oe_cycles", 136'(mon_n), 136'(48));
            end
            mon_n = 0;
        end else if (!transmission_complete) begin
            mon_n = 0;
        end
        if (reception_complete && !prev_rc) begin
            if (exp_rx_q.size() == 0) begin
                total++; bad++;
                $display("FAIL rx_unexpected: got response %h expected none", pad_response);
            end else begin
                check("rx_response", pad_response, exp_rx_q.pop_front());
                check("rx_flags", 136'({crc_error, end_bit_error}), 136'(exp_flag_q.pop_front()));
            end
        end
        prev_tc = transmission_complete;
        prev_rc = reception_complete;
    end

    // Sends one frame; leaves enable_pts high in TX_DONE for the caller
    task automatic do_tx(input logic [5:0] idx, input logic [31:0] arg, input logic [47:0] exp);
        @(posedge sd_clock); #1;
        enable_pts = 1'b1; cmd_index = idx; cmd_arg = arg; load_send = 1'b1;
        exp_tx_q.push_back(exp);
        @(posedge sd_clock); #1;
        load_send = 1'b0;
        check("tx_oe_start", 136'(cmd_oe), 136'(1));
        repeat (47) @(posedge sd_clock);
        #1;
        check("tx_busy_tc", 136'({cmd_oe, transmission_complete}), 136'(2'b10));
        @(posedge sd_clock); #1;
        check("tx_done_lvl", 136'({cmd_oe, cmd_out, transmission_complete}), 136'(3'b011));
        load_send = 1'b1;
        @(posedge sd_clock); #1;
        check("tx_load_ignored", 136'({cmd_oe, transmission_complete}), 136'(2'b01));
        load_send = 1'b0;
    endtask

    task automatic tx_frame(input logic [5:0] idx, input logic [31:0] arg, input logic [47:0] exp);
        do_tx(idx, arg, exp);
        enable_pts = 1'b0;
        @(posedge sd_clock); #1;
        check("tx_back_idle", 136'(transmission_complete), 136'(0));
    endtask

    task automatic send_rx(input logic [135:0] frame, input int len, input logic lr, input logic [1:0] flags);
        exp_rx_q.push_back(frame);
        exp_flag_q.push_back(flags);
        @(posedge sd_clock); #1;
        enable_stp = 1'b1; long_response = lr; cmd_in = 1'b1;
        repeat (10) begin
            @(posedge sd_clock); #1;
        end
        for (int i = len - 1; i >= 0; i--) begin
            cmd_in = frame[i];
            @(posedge sd_clock); #1;
            if (i == 1) check("rx_not_early", 136'(reception_complete), 136'(0));
        end
        check("rx_done_lvl", 136'(reception_complete), 136'(1));
        cmd_in = 1'b1; enable_stp = 1'b0; long_response = 1'b0;
        @(posedge sd_clock); #1;
        check("rx_clear_lvl", 136'(reception_complete), 136'(0));
    endtask

    function automatic logic [47:0] resp_frame(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] m;
        m = {2'b00, idx, arg};
        return {m, crc7_ref({88'd0, m}, 40), 1'b1};
    endfunction

    initial begin
        logic [5:0]   idx;
        logic [31:0]  arg;
        logic [47:0]  f48;
        logic [119:0] pay;
        logic [127:0] rnd;
        logic [135:0] f136;
        logic [135:0] held;
        int           err;
        logic         seen;

        #22;
        check("reset_outputs", 136'({cmd_out, cmd_oe, transmission_complete, reception_complete, crc_error, end_bit_error}), 136'(6'b100000));
        check("reset_pad", pad_response, 136'd0);
        @(negedge sd_clock);
        reset = 1'b1;

        // Directed command frames
        tx_frame(6'd0, 32'h0000_0000, 48'h40_0000_0000_95);
        tx_frame(6'd8, 32'h0000_01AA, 48'h48_0000_01AA_87);
        // Random command frames against the reference model
        for (int n = 0; n < 6; n++) begin
            idx = 6'($urandom_range(0, 63));
            arg = $urandom;
            tx_frame(idx, arg, cmd_frame(idx, arg));
        end

        // Directed R7 response: clean, bad CRC, bad end bit
        send_rx(136'h08_0000_01AA_13, 48, 1'b0, 2'b00);
        send_rx(136'h08_0000_01AA_11, 48, 1'b0, 2'b10);
        send_rx(136'h08_0000_01AA_12, 48, 1'b0, 2'b01);

        // Synchronous clear during a frame wins over enable/load
        @(posedge sd_clock); #1;
        enable_pts = 1'b1; load_send = 1'b1; cmd_index = 6'd17; cmd_arg = 32'hDEAD_BEEF;
        @(posedge sd_clock); #1;
        load_send = 1'b0;
        repeat (5) @(posedge sd_clock);
        #1;
        reset_wrapper = 1'b1; load_send = 1'b1;
        @(posedge sd_clock); #1;
        check("wrap_tx_clear", 136'({cmd_oe, cmd_out, transmission_complete}), 136'(3'b010));
        check("wrap_rx_clear", pad_response, 136'd0);
        check("wrap_flags", 136'({crc_error, end_bit_error}), 136'(2'b00));
        reset_wrapper = 1'b0; load_send = 1'b0; enable_pts = 1'b0;
        @(posedge sd_clock); #1;

        // Random short responses with occasional injected faults
        for (int n = 0; n < 6; n++) begin
            idx = 6'($urandom_range(0, 63));
            arg = $urandom;
            f48 = resp_frame(idx, arg);
            err = int'($urandom_range(0, 2));
            if (err == 1) f48[1] = ~f48[1];
            if (err == 2) f48[0] = 1'b0;
            send_rx({88'd0, f48}, 48, 1'b0, {err == 1, err == 2});
        end
        // Random R2 responses
        for (int n = 0; n < 2; n++) begin
            rnd  = {$urandom, $urandom, $urandom, $urandom};
            pay  = rnd[119:0];
            f136 = {8'h3F, pay, crc7_ref({8'd0, pay}, 120), 1'b1};
            send_rx(f136, 136, 1'b1, 2'b00);
        end

        // Both enables high: only TX runs, RX ignores the line
        held = pad_response;
        @(posedge sd_clock); #1;
        enable_pts = 1'b1; enable_stp = 1'b1;
        do_tx(6'd55, 32'h1234_5678, cmd_frame(6'd55, 32'h1234_5678));
        f48  = resp_frame(6'd3, 32'hCAFE_F00D);
        seen = 1'b0;
        for (int i = 47; i >= 0; i--) begin
            cmd_in = f48[i];
            @(posedge sd_clock); #1;
            seen = seen | reception_complete;
        end
        check("both_en_no_rx", 136'(seen), 136'(0));
        check("both_en_pad_kept", pad_response, held);
        cmd_in = 1'b1; enable_pts = 1'b0; enable_stp = 1'b0;
        @(posedge sd_clock); #1;

        // enable_pts dropped mid-frame aborts without completion
        @(posedge sd_clock); #1;
        enable_pts = 1'b1; load_send = 1'b1; cmd_index = 6'd2; cmd_arg = 32'h0F0F_0F0F;
        @(posedge sd_clock); #1;
        load_send = 1'b0;
        repeat (10) @(posedge sd_clock);
        #1;
        enable_pts = 1'b0;
        @(posedge sd_clock); #1;
        check("abort_oe", 136'({cmd_oe, cmd_out}), 136'(2'b01));
        seen = 1'b0;
        repeat (60) begin
            @(posedge sd_clock); #1;
            seen = seen | transmission_complete | cmd_oe;
        end
        check("abort_no_tc", 136'(seen), 136'(0));

        // Asynchronous reset at TX bit 20
        @(posedge sd_clock); #1;
        enable_pts = 1'b1; load_send = 1'b1; cmd_index = 6'd41; cmd_arg = 32'hA5A5_5A5A;
        @(posedge sd_clock); #1;
        load_send = 1'b0;
        repeat (20) @(posedge sd_clock);
        #3;
        check("areset_pre_oe", 136'(cmd_oe), 136'(1));
        reset = 1'b0;
        #1;
        check("areset_outputs", 136'({cmd_out, cmd_oe, transmission_complete, reception_complete, crc_error, end_bit_error}), 136'(6'b100000));
        check("areset_pad", pad_response, 136'd0);
        enable_pts = 1'b0;
        @(negedge sd_clock);
        reset = 1'b1;
        @(posedge sd_clock); #1;
        check("areset_idle", 136'({cmd_oe, transmission_complete}), 136'(2'b00));

        repeat (3) @(posedge sd_clock);
        #1;
        check("queues_drained", 136'(exp_tx_q.size() + exp_rx_q.size()), 136'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/sd_cmd_serdes.md
Name: sd_cmd_serdes

Overview:
- Command-line serializer/deserializer between the command physical controller and the SD CMD pad.
- TX: takes a 6-bit command index and 32-bit argument, builds the 48-bit SD command frame with CRC7, and shifts it out MSB-first.
- RX: waits for a response start bit, captures a 48- or 136-bit response, checks CRC7 and end bit, and presents the response in parallel with completion levels.
- Sits directly below the controller, driven by its enable_pts_wrapper, enable_stp_wrapper, load_send and reset_wrapper outputs.

Parameters:
- CMD_BITS, 48, transmitted frame length.
- SHORT_RESP_BITS, 48, R1/R3/R6/R7 response length.
- LONG_RESP_BITS, 136, R2 response length; also the width of pad_response.

Ports:
- sd_clock  in  1  sole clock; all flops rise on its posedge.
- reset  in  1  asynchronous, active-low reset.
- reset_wrapper  in  1  synchronous clear, active-high; same effect as reset except it acts at a clock edge.
- enable_pts  in  1  TX path enable.
- enable_stp  in  1  RX path enable.
- load_send  in  1  start TX when high and TX is idle.
- cmd_index  in  6  command index.
- cmd_arg  in  32  command argument.
- long_response  in  1  1 = expect 136-bit response, 0 = 48-bit; sampled when RX leaves RX_IDLE.
- cmd_in  in  1  serial data from the pad.
- cmd_out  out  1  serial data to the pad.
- cmd_oe  out  1  pad output enable.
- transmission_complete  out  1  level: frame fully sent.
- reception_complete  out  1  level: response fully captured.
- pad_response  out  136  captured response, right-aligned, zero-extended.
- crc_error  out  1  CRC7 mismatch on the last response.
- end_bit_error  out  1  last response bit was not 1.

Behaviour:
- Reset/clear values: cmd_out=1, cmd_oe=0, transmission_complete=0, reception_complete=0, pad_response=0, crc_error=0, end_bit_error=0; both FSMs go to IDLE, and counters and the CRC register go to 0.
  - reset_wrapper takes precedence over every other input.
- CRC7: polynomial x^7+x^3+1, register initialised to 0, computed serially one bit per cycle.
- TX FSM states: TX_IDLE, TX_SHIFT, TX_DONE.
  - TX_IDLE -> TX_SHIFT when enable_pts && load_send sampled at edge k.
  - At edge k the shifter loads {0,1,cmd_index,cmd_arg}; CRC7 accumulates the first 40 bits as they shift out.
  - Frame bits 47..0 are driven on cmd_out after edges k..k+47, in this order: start 0, transmission 1, index, argument, CRC7 (7 bits), end 1.
  - cmd_oe=1 for exactly those 48 cycles.
  - After edge k+48: TX_DONE, cmd_oe=0, cmd_out=1, transmission_complete=1.
  - TX_DONE holds until reset_wrapper or enable_pts=0, then returns to TX_IDLE.
  - load_send while in TX_SHIFT or TX_DONE is ignored.
  - enable_pts falling during TX_SHIFT aborts the frame: next edge goes to TX_IDLE with cmd_oe=0, and transmission_complete stays 0.
- RX FSM states: RX_IDLE, RX_WAIT, RX_SHIFT, RX_DONE.
  - RX_IDLE -> RX_WAIT when enable_stp && !enable_pts && !cmd_oe; long_response is latched into len (48 or 136).
  - RX_WAIT: cmd_in is sampled every edge, with no internal timeout (the controller owns the timeout). The first sampled 0 is frame bit len-1; the counter is set to len-2 and the FSM enters RX_SHIFT.
  - RX_SHIFT: one bit per edge, shifted in MSB-first.
  - CRC coverage: short responses run CRC over frame bits 47..8; long responses over bits 127..8, skipping the first 8 bits. The received 7 bits are then compared.
  - On capture of bit 0: RX_DONE. In the same edge pad_response is loaded, reception_complete=1, crc_error=(mismatch), end_bit_error=~bit0.
  - RX_DONE holds outputs until reset_wrapper or enable_stp=0, then returns to RX_IDLE. pad_response retains its value until the next capture or clear.
  - enable_stp falling before RX_DONE aborts to RX_IDLE; pad_response and the flags are unchanged.
- Simultaneous enable_pts and enable_stp: TX wins and RX stays in RX_IDLE; the bus is never driven while receiving.
- Asynchronous reset mid-frame: cmd_oe drops immediately, with no glitch on cmd_out past the reset assertion.

Test Plan:
- cmd_index=0, cmd_arg=0, load_send at edge k -> cmd_out stream 0x40_0000_0000_95 over 48 cycles, cmd_oe high exactly 48 cycles, transmission_complete high from edge k+48.
- cmd_index=8, cmd_arg=0x000001AA -> serialized frame 0x48_0000_01AA_87.
- enable_stp with long_response=0, 10 idle 1s, then serial 0x08_0000_01AA_13 -> pad_response=136'h...0008000001AA13, reception_complete=1, crc_error=0, end_bit_error=0.
- Same response with the last CRC bit flipped -> crc_error=1. Same response with end bit 0 -> end_bit_error=1. reception_complete=1 in both cases.
- long_response=1, 136-bit R2 with valid CRC -> full 136 bits captured, reception_complete after 136 bit-cycles, crc_error=0.
- Disturbances:
  - reset low at TX bit 20 -> cmd_oe=0 asynchronously, all outputs at reset values.
  - enable_pts and enable_stp both high -> only TX runs.
  - enable_pts dropped mid-frame -> transmission_complete stays 0.
